// File: rtl/std_fifo_wrr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : std_fifo_wrr_scheduler
// Purpose  : Weighted round-robin drain of N std_fifo queues onto one
//            registered valid/ready stream, at most one pop per cycle.
// Revision : 1.0
// ============================================================================
module std_fifo_wrr_scheduler #(
    parameter int  N            = 4,
    parameter int  WIDTH        = 8,
    parameter type TYPE         = logic [WIDTH-1:0],
    parameter int  WEIGHT_WIDTH = 4,
    localparam int SRC_WIDTH    = $clog2(N)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_clear,
    input  logic [N*WEIGHT_WIDTH-1:0] i_weight,
    input  logic [N-1:0]              i_fifo_empty,
    input  TYPE                       i_fifo_data [N],
    output logic [N-1:0]              o_fifo_pop,
    output logic                      o_valid,
    input  logic                      i_ready,
    output TYPE                       o_data,
    output logic [SRC_WIDTH-1:0]      o_source
);

    localparam logic [SRC_WIDTH-1:0] C_GRANT_RST = SRC_WIDTH'(N - 1);

    logic [SRC_WIDTH-1:0]    r_grant;
    logic [WEIGHT_WIDTH-1:0] r_credit;
    logic                    r_valid;
    TYPE                     r_data;
    logic [SRC_WIDTH-1:0]    r_source;

    logic                    w_le;
    logic                    w_stay;
    logic                    w_found;
    logic                    w_pop_en;
    logic [SRC_WIDTH-1:0]    w_sel;
    logic [SRC_WIDTH-1:0]    w_cand;
    logic [WEIGHT_WIDTH-1:0] w_reload;
    logic [WEIGHT_WIDTH-1:0] w_weight [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_weight
            assign w_weight[gi] = i_weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
    endgenerate

    always_comb begin
        w_le     = !r_valid || i_ready;
        w_stay   = !i_fifo_empty[r_grant] && (r_credit != '0);
        w_sel    = r_grant;
        w_found  = w_stay;
        w_cand   = r_grant;
        if (!w_stay) begin
            // Walk downward so the nearest queue after the grant wins; the
            // grant itself (k = N) has the lowest priority.
            for (int k = N; k >= 1; k--) begin
                w_cand = SRC_WIDTH'((int'(r_grant) + k) % N);
                if (!i_fifo_empty[w_cand]) begin
                    w_sel   = w_cand;
                    w_found = 1'b1;
                end
            end
        end
        w_reload = (w_weight[w_sel] == '0) ? '0 : w_weight[w_sel] - WEIGHT_WIDTH'(1);
        w_pop_en = i_rst && w_le && !i_clear && w_found;
    end

    generate
        for (gi = 0; gi < N; gi++) begin : g_pop
            assign o_fifo_pop[gi] = w_pop_en && (w_sel == SRC_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_grant  <= C_GRANT_RST;
            r_credit <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_source <= '0;
        end else if (i_clear) begin
            r_grant  <= C_GRANT_RST;
            r_credit <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_source <= '0;
        end else if (w_le) begin
            if (w_found) begin
                r_grant  <= w_sel;
                r_credit <= w_stay ? r_credit - WEIGHT_WIDTH'(1) : w_reload;
                r_valid  <= 1'b1;
                r_data   <= i_fifo_data[w_sel];
                r_source <= w_sel;
            end else begin
                r_valid  <= 1'b0;
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_source = r_source;

endmodule
`default_nettype wire

// File: tb/tb_std_fifo_wrr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_std_fifo_wrr_scheduler
// Purpose  : Directed bench for the WRR drain scheduler with modelled FIFOs.
// Revision : 1.0
// ============================================================================
module tb_std_fifo_wrr_scheduler;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [15:0] weight;
    logic [3:0]  fempty;
    logic [7:0]  fdata [4];
    logic [3:0]  pop;
    logic        valid;
    logic        ready;
    logic [7:0]  odata;
    logic [1:0]  osrc;

    int          total;
    int          bad;
    int          cnt  [4];
    int          nxt  [4];
    int          ecnt [4];
    logic [7:0]  base [4];
    logic [3:0]  pop_s;
    logic [7:0]  held;

    std_fifo_wrr_scheduler #(
        .N            (4),
        .WIDTH        (8),
        .WEIGHT_WIDTH (4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_clear      (clear),
        .i_weight     (weight),
        .i_fifo_empty (fempty),
        .i_fifo_data  (fdata),
        .o_fifo_pop   (pop),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_data       (odata),
        .o_source     (osrc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            fempty[k] = (cnt[k] == 0);
            fdata[k]  = base[k] + 8'(nxt[k]);
        end
    endtask

    task automatic fill(input int k, input int n, input logic [7:0] b);
        cnt[k]  = n;
        nxt[k]  = 0;
        ecnt[k] = 0;
        base[k] = b;
        drive();
    endtask

    // Entered at edge+1; samples pops mid-cycle, then retires popped heads.
    task automatic tick();
        #4;
        pop_s = pop;
        chk("pop_legal", 32'(pop_s & fempty), 32'd0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (pop_s[k]) begin
                nxt[k]++;
                cnt[k]--;
            end
        end
        drive();
    endtask

    task automatic expw(input string tag, input int s);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_src"}, 32'(osrc), 32'(s));
        chk({tag, "_data"}, 32'(odata), 32'(8'(base[s] + 8'(ecnt[s]))));
        ecnt[s]++;
    endtask

    int seq2 [7] = '{0, 0, 0, 1, 2, 3, 3};

    initial begin
        total  = 0;
        bad    = 0;
        clk    = 1'b0;
        rst    = 1'b0;
        clear  = 1'b0;
        ready  = 1'b1;
        weight = 16'h1111;
        for (int k = 0; k < 4; k++) fill(k, 0, 8'h00);
        fill(1, 3, 8'h40);

        // Reset state, with a non-empty queue present
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'(odata), 32'd0);
        chk("rst_src", 32'(osrc), 32'd0);
        chk("rst_pop", 32'(pop), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Equal weights
        fill(0, 3, 8'h10); fill(1, 3, 8'h40); fill(2, 3, 8'h70); fill(3, 3, 8'hA0);
        for (int i = 0; i < 12; i++) begin
            tick();
            expw("eq", i % 4);
        end
        tick();
        chk("eq_idle_valid", 32'(valid), 32'd0);

        // Weighted quotas {3,1,0,2}
        weight = 16'h2013;
        fill(0, 40, 8'h10); fill(1, 40, 8'h40); fill(2, 40, 8'h70); fill(3, 40, 8'hA0);
        for (int i = 0; i < 14; i++) begin
            tick();
            expw("wt", seq2[i % 7]);
        end

        // Backpressure: last word was from queue 3
        held  = base[3] + 8'(ecnt[3] - 1);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_pop", 32'(pop_s), 32'd0);
            chk("bp_valid", 32'(valid), 32'd1);
            chk("bp_src", 32'(osrc), 32'd3);
            chk("bp_data", 32'(odata), 32'(held));
        end
        ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            expw("bp_resume", seq2[i]);
        end

        // Clear, then early empty
        clear = 1'b1;
        tick();
        chk("clr1_pop", 32'(pop_s), 32'd0);
        chk("clr1_valid", 32'(valid), 32'd0);
        clear  = 1'b0;
        weight = 16'h1114;
        fill(0, 2, 8'h10); fill(1, 3, 8'h40); fill(2, 0, 8'h70); fill(3, 0, 8'hA0);
        tick(); expw("ee0", 0);
        tick(); expw("ee1", 0);
        tick(); expw("ee2", 1);
        chk("ee_pop1", 32'(pop_s), 32'h2);
        tick(); expw("ee3", 1);
        tick(); expw("ee4", 1);
        tick();
        chk("ee_idle_valid", 32'(valid), 32'd0);

        // Idle then single word
        tick();
        chk("idle_valid", 32'(valid), 32'd0);
        fill(2, 1, 8'hA5);
        tick();
        chk("single_pop", 32'(pop_s), 32'h4);
        expw("single", 2);
        tick();
        chk("single_after", 32'(valid), 32'd0);

        // Clear mid-stream from queue 2
        fill(2, 10, 8'h20);
        tick(); expw("cs0", 2);
        tick(); expw("cs1", 2);
        clear = 1'b1;
        fill(0, 5, 8'h10); fill(3, 5, 8'hA0);
        tick();
        chk("clr2_pop", 32'(pop_s), 32'd0);
        chk("clr2_valid", 32'(valid), 32'd0);
        clear = 1'b0;
        tick(); expw("cs_after", 0);

        // Asynchronous reset mid-cycle drops the held word
        #4;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_src", 32'(osrc), 32'd0);
        chk("arst_data", 32'(odata), 32'd0);
        chk("arst_pop", 32'(pop), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
